// File: rtl/wash_pkg.sv
// wash_pkg: phase encoding, default timer width and phase-sequencing helpers
// Define WASH_CONTROLLER_DRY_EN to add the DRY phase (encoding 5) between SPIN and DONE.
package wash_pkg;
  localparam int TW_DEF = 16;
`ifdef WASH_CONTROLLER_DRY_EN
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    WASH  = 3'd2,
    RINSE = 3'd3,
    SPIN  = 3'd4,
    DRY   = 3'd5,
    DONE  = 3'd6
  } phase_e;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    WASH  = 3'd2,
    RINSE = 3'd3,
    SPIN  = 3'd4,
    DONE  = 3'd6
  } phase_e;
`endif
  function automatic logic is_active(input phase_e s);
    return (s != IDLE) && (s != DONE);
  endfunction
  function automatic phase_e next_phase(input phase_e s);
`ifdef WASH_CONTROLLER_DRY_EN
    return s == FILL ? WASH : s == WASH ? RINSE : s == RINSE ? SPIN : s == SPIN ? DRY : DONE;
`else
    return s == FILL ? WASH : s == WASH ? RINSE : s == RINSE ? SPIN : DONE;
`endif
  endfunction
endpackage

// File: rtl/phase_timer.sv
// phase_timer: per-phase cycle counter; expire is combinational when count == ticks-1 (ticks==0 acts as 1)
// Ports: clk, reset (sync, active-high), clear (zero counter), hold (freeze counter), ticks (phase length), expire.
module phase_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         hold,
  input  logic [W-1:0] ticks,
  output logic         expire
);
  logic [W-1:0] count_q, count_d, last;
  always_comb begin
    last    = (ticks == '0) ? '0 : ticks - W'(1);
    count_d = clear ? '0 : hold ? count_q : count_q + W'(1);
    expire  = count_q == last;
  end
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end
endmodule

// File: rtl/wash_controller.sv
// wash_controller: timed FILL/WASH/RINSE/SPIN(/DRY) sequencer with pause and lid interlock
// Ports: clk, reset (sync, active-high), start, pause, lid_open, clk_freq and *_sec durations (TW bits),
//   phase (state encoding), water_valve, motor_on, spin_mode, door_lock, done (one-cycle pulse).
// Define WASH_CONTROLLER_DRY_EN to add dry_sec and the DRY phase.
module wash_controller
  import wash_pkg::*;
#(
  parameter int TW = TW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          pause,
  input  logic          lid_open,
  input  logic [TW-1:0] clk_freq,
  input  logic [TW-1:0] fill_sec,
  input  logic [TW-1:0] wash_sec,
  input  logic [TW-1:0] rinse_sec,
  input  logic [TW-1:0] spin_sec,
`ifdef WASH_CONTROLLER_DRY_EN
  input  logic [TW-1:0] dry_sec,
`endif
  output logic [2:0]    phase,
  output logic          water_valve,
  output logic          motor_on,
  output logic          spin_mode,
  output logic          door_lock,
  output logic          done
);
  phase_e        state_q, state_d;
  logic [TW-1:0] freq_q, freq_d, fill_q, fill_d, wash_q, wash_d, rinse_q, rinse_d, spin_q, spin_d;
  logic [TW-1:0] dur_sel;
  logic [2*TW-1:0] ticks;
  logic active, paused, go, expire, clear, paused_d;
  logic water_q, water_d, motor_q, motor_d, spinm_q, spinm_d, lock_q, lock_d, done_q, done_d;
`ifdef WASH_CONTROLLER_DRY_EN
  logic [TW-1:0] dry_q, dry_d;
  assign dur_sel = state_q == FILL ? fill_q : state_q == WASH ? wash_q :
                   state_q == RINSE ? rinse_q : state_q == SPIN ? spin_q : dry_q;
`else
  assign dur_sel = state_q == FILL ? fill_q : state_q == WASH ? wash_q :
                   state_q == RINSE ? rinse_q : spin_q;
`endif
  assign ticks = {{TW{1'b0}}, freq_q} * {{TW{1'b0}}, dur_sel};
  phase_timer #(.W(2 * TW)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .hold  (paused),
    .ticks (ticks),
    .expire(expire)
  );
  always_comb begin
    active   = is_active(state_q);
    paused   = active && (pause || lid_open);
    go       = (state_q == IDLE) && start && !lid_open;
    state_d  = go ? FILL : (active && !paused && expire) ? next_phase(state_q) :
               (state_q == DONE) ? IDLE : state_q;
    clear    = (state_d != state_q) || !active;
    freq_d   = go ? clk_freq : freq_q;
    fill_d   = go ? fill_sec : fill_q;
    wash_d   = go ? wash_sec : wash_q;
    rinse_d  = go ? rinse_sec : rinse_q;
    spin_d   = go ? spin_sec : spin_q;
`ifdef WASH_CONTROLLER_DRY_EN
    dry_d    = go ? dry_sec : dry_q;
    motor_d  = state_d inside {WASH, RINSE, SPIN, DRY};
    spinm_d  = state_d inside {SPIN, DRY};
`else
    motor_d  = state_d inside {WASH, RINSE, SPIN};
    spinm_d  = state_d == SPIN;
`endif
    // Outputs are computed from the next state so they land in the same cycle as the phase register.
    paused_d = is_active(state_d) && (pause || lid_open);
    water_d  = !paused_d && (state_d inside {FILL, RINSE});
    motor_d  = motor_d && !paused_d;
    spinm_d  = spinm_d && !paused_d;
    lock_d   = is_active(state_d);
    done_d   = state_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      freq_q  <= '0;
      fill_q  <= '0;
      wash_q  <= '0;
      rinse_q <= '0;
      spin_q  <= '0;
`ifdef WASH_CONTROLLER_DRY_EN
      dry_q   <= '0;
`endif
      water_q <= 1'b0;
      motor_q <= 1'b0;
      spinm_q <= 1'b0;
      lock_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      freq_q  <= freq_d;
      fill_q  <= fill_d;
      wash_q  <= wash_d;
      rinse_q <= rinse_d;
      spin_q  <= spin_d;
`ifdef WASH_CONTROLLER_DRY_EN
      dry_q   <= dry_d;
`endif
      water_q <= water_d;
      motor_q <= motor_d;
      spinm_q <= spinm_d;
      lock_q  <= lock_d;
      done_q  <= done_d;
    end
  end
  assign phase       = state_q;
  assign water_valve = water_q;
  assign motor_on    = motor_q;
  assign spin_mode   = spinm_q;
  assign door_lock   = lock_q;
  assign done        = done_q;
endmodule

// File: tb/tb_wash_controller.sv
// tb_wash_controller: directed self-checking bench for wash_controller
module tb_wash_controller;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, pause = 1'b0, lid_open = 1'b0;
  logic [15:0] clk_freq = 16'd10, fill_sec = 16'd1, wash_sec = 16'd2, rinse_sec = 16'd1, spin_sec = 16'd3;
`ifdef WASH_CONTROLLER_DRY_EN
  logic [15:0] dry_sec = 16'd2;
`endif
  logic [2:0]  phase;
  logic        water_valve, motor_on, spin_mode, door_lock, done;
  int tests = 0, fails = 0;
  wash_controller #(.TW(16)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .lid_open(lid_open),
    .clk_freq(clk_freq), .fill_sec(fill_sec), .wash_sec(wash_sec), .rinse_sec(rinse_sec), .spin_sec(spin_sec),
`ifdef WASH_CONTROLLER_DRY_EN
    .dry_sec(dry_sec),
`endif
    .phase(phase), .water_valve(water_valve), .motor_on(motor_on), .spin_mode(spin_mode),
    .door_lock(door_lock), .done(done)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic measure(input int p, input int start_n, input int exp_len, input string tag);
    int n;
    n = start_n;
    while (int'(phase) == p && n < 2000) begin
      n++;
      step();
    end
    chk(tag, n, exp_len);
  endtask
  task automatic wait_for(input int p, input string tag);
    int n;
    n = 0;
    while (int'(phase) != p && n < 2000) begin
      n++;
      step();
    end
    chk(tag, int'(phase), p);
  endtask
  task automatic do_start(input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    chk(tag, int'(phase), 1);
  endtask
  task automatic tail(input string tag);
    measure(4, 0, 30, {tag, "_spin_len"});
`ifdef WASH_CONTROLLER_DRY_EN
    chk({tag, "_dry_motor"}, int'(motor_on), 1);
    chk({tag, "_dry_spin"}, int'(spin_mode), 1);
    chk({tag, "_dry_water"}, int'(water_valve), 0);
    measure(5, 0, 20, {tag, "_dry_len"});
`endif
    chk({tag, "_done_phase"}, int'(phase), 6);
    chk({tag, "_done_pulse"}, int'(done), 1);
    chk({tag, "_done_lock"}, int'(door_lock), 0);
    step();
    chk({tag, "_idle_phase"}, int'(phase), 0);
    chk({tag, "_done_clear"}, int'(done), 0);
  endtask
  initial begin
    repeat (3) step();
    chk("rst_phase", int'(phase), 0);
    chk("rst_outs", int'({water_valve, motor_on, spin_mode, door_lock, done}), 0);
    reset = 1'b0;
    step();
    chk("idle_stays", int'(phase), 0);
    // nominal cycle, with a stray start during WASH
    do_start("nom_start");
    chk("nom_fill_water", int'(water_valve), 1);
    chk("nom_fill_lock", int'(door_lock), 1);
    chk("nom_fill_motor", int'(motor_on), 0);
    measure(1, 0, 10, "nom_fill_len");
    chk("nom_wash_motor", int'(motor_on), 1);
    chk("nom_wash_water", int'(water_valve), 0);
    repeat (3) step();
    start = 1'b1;
    step();
    start = 1'b0;
    measure(2, 4, 20, "nom_wash_len");
    chk("nom_rinse_water", int'(water_valve), 1);
    chk("nom_rinse_motor", int'(motor_on), 1);
    measure(3, 0, 10, "nom_rinse_len");
    chk("nom_spin_mode", int'(spin_mode), 1);
    tail("nom");
    // pause 7 cycles starting at WASH cycle 5
    do_start("pau_start");
    measure(1, 0, 10, "pau_fill_len");
    repeat (5) step();
    pause = 1'b1;
    step();
    chk("pau_motor_off", int'(motor_on), 0);
    chk("pau_lock_on", int'(door_lock), 1);
    chk("pau_phase_held", int'(phase), 2);
    repeat (6) step();
    chk("pau_motor_still_off", int'(motor_on), 0);
    pause = 1'b0;
    measure(2, 12, 27, "pau_wash_len");
    wait_for(6, "pau_reach_done");
    step();
    // lid interlock
    lid_open = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("lid_start_ignored", int'(phase), 0);
    chk("lid_idle_lock", int'(door_lock), 0);
    lid_open = 1'b0;
    do_start("lid_start");
    wait_for(4, "lid_reach_spin");
    repeat (2) step();
    lid_open = 1'b1;
    step();
    chk("lid_spin_mode", int'(spin_mode), 0);
    chk("lid_motor", int'(motor_on), 0);
    chk("lid_lock", int'(door_lock), 1);
    chk("lid_phase", int'(phase), 4);
    lid_open = 1'b0;
    step();
    chk("lid_spin_resume", int'(spin_mode), 1);
    wait_for(6, "lid_reach_done");
    step();
    // zero wash duration; input change after start must not take effect
    wash_sec = 16'd0;
    do_start("zero_start");
    wash_sec = 16'd5;
    clk_freq = 16'd3;
    measure(1, 0, 10, "zero_fill_len");
    measure(2, 0, 1, "zero_wash_len");
    measure(3, 0, 10, "zero_rinse_len");
    tail("zero");
    // reset mid-RINSE, then a full cycle
    wash_sec = 16'd2;
    clk_freq = 16'd10;
    do_start("rst_start");
    wait_for(3, "rst_reach_rinse");
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_mid_phase", int'(phase), 0);
    chk("rst_mid_outs", int'({water_valve, motor_on, spin_mode, door_lock, done}), 0);
    do_start("rst_restart");
    measure(1, 0, 10, "rst_fill_len");
    measure(2, 0, 20, "rst_wash_len");
    measure(3, 0, 10, "rst_rinse_len");
    tail("rst");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wash_controller.md
WASH_CONTROLLER -- requirements
Module: wash_controller

Interface
REQ-001 SHALL have parameter TW, default 16, width of the clk_freq and per-phase duration inputs.
REQ-002 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: start a cycle, sampled only in IDLE.
REQ-005 SHALL have port pause, input, 1: level-sensitive freeze of the current phase.
REQ-006 SHALL have port lid_open, input, 1: lid sensor; high acts as pause in any active phase.
REQ-007 SHALL have port clk_freq, input, TW: clock ticks per second.
REQ-008 SHALL have ports fill_sec, wash_sec, rinse_sec, spin_sec, input, TW each: phase durations in seconds.
REQ-009 SHALL have port phase, output, 3: encoded current state.
REQ-010 SHALL have ports water_valve, motor_on, spin_mode, door_lock, output, 1 each: actuator drives.
REQ-011 SHALL have port done, output, 1: one-cycle completion pulse.

Function
REQ-012 SHALL implement states IDLE=0, FILL=1, WASH=2, RINSE=3, SPIN=4, DONE=6, with paused status held in a separate flag and not as a state.
REQ-013 SHALL move IDLE->FILL on the clock edge where start=1 and lid_open=0; start with lid_open=1 SHALL be ignored.
REQ-014 SHALL latch clk_freq and all *_sec inputs on the IDLE->FILL transition; later input changes SHALL NOT affect the running cycle.
REQ-015 SHALL size a phase at ticks = clk_freq*dur, computed as a 2*TW-bit product with no truncation.
REQ-016 SHALL count cycles in a phase counter cleared on phase entry and advance the phase on the edge where counter == ticks-1.
REQ-017 SHALL give a phase with ticks==0 (dur=0 or clk_freq=0) a duration of exactly one cycle.
REQ-018 SHALL follow the phase order FILL->WASH->RINSE->SPIN->DONE.
REQ-019 SHALL remain in DONE for exactly one cycle with done=1, then return to IDLE.
REQ-020 SHALL, while pause|lid_open is high in FILL..SPIN, hold the counter and state and drive water_valve, motor_on and spin_mode to 0; the counter SHALL resume from its held value on release.
REQ-021 SHALL drive water_valve=1 only in FILL and RINSE when not paused.
REQ-022 SHALL drive motor_on=1 in WASH, RINSE and SPIN when not paused, and spin_mode=1 in SPIN only.
REQ-023 SHALL drive door_lock=1 in FILL..SPIN including paused, and 0 in IDLE and DONE.
REQ-024 SHALL ignore start in every state other than IDLE.
REQ-025 SHALL register all outputs, with the output state aligned to the phase register in the same cycle.

Reset
REQ-026 SHALL, on reset=1 at a clock edge, from any state including mid-phase or paused, set phase=IDLE, counter=0, paused flag=0, all outputs=0, and clear the latched durations.
REQ-027 SHALL give reset priority over start, pause and timer expiry in the same cycle.

Configuration
REQ-028 SHALL, with macro WASH_CONTROLLER_DRY_EN defined, add input dry_sec (TW) and state DRY=5 between SPIN and DONE, with motor_on=1, spin_mode=1, water_valve=0, and door_lock=1.
REQ-029 SHALL, without WASH_CONTROLLER_DRY_EN, have no dry_sec port, leave encoding 5 unused, and go SPIN->DONE directly.

Structure
REQ-030 SHALL place the phase encoding enum and the TW default constant in shared package wash_pkg.
REQ-031 SHALL implement the counter in sub-module phase_timer (clk, reset, clear, hold, ticks, expire), which has a synchronous reset and asserts expire combinationally when count==ticks-1 (ticks==0 treated as 1).

Verification
REQ-032 SHALL verify the nominal cycle: clk_freq=10, fill/wash/rinse/spin=1/2/1/3, start pulse -> FILL 10, WASH 20, RINSE 10, SPIN 30 cycles, then done=1 for one cycle and phase=IDLE.
REQ-033 SHALL verify pause: pause high for 7 cycles at WASH cycle 5 -> motor_on=0 during the pause, and WASH lasts 27 cycles total.
REQ-034 SHALL verify lid interlock: start with lid_open=1 -> phase stays IDLE; lid_open=1 during SPIN -> spin_mode=0 while door_lock stays 1.
REQ-035 SHALL verify zero duration: wash_sec=0 -> WASH lasts exactly 1 cycle.
REQ-036 SHALL verify reset mid-RINSE -> next cycle phase=IDLE with all outputs 0; a following start runs the full FILL duration.
REQ-037 SHALL verify a full cycle with WASH_CONTROLLER_DRY_EN defined and dry_sec=2, clk_freq=10 -> a 20-cycle DRY phase follows SPIN before done.
